serial_variable_shifter: RTL
============================

Name: serial_variable_shifter

Overview:
Time-multiplexed variable shifter. It computes a shift of `a` by `shift_width` bits, one bit per clock, using a single 1-bit shift step instead of a barrel network.
- Parametrised successor to the 8-bit left-only serial shifter, with these additions:
  - configurable WIDTH
  - four shift modes
  - operands captured on `start`, so inputs need not be held during the operation
  - explicit start/busy/done handshake
- Used in area-constrained datapaths where a result latency of `shift_width`+1 cycles is acceptable.

Parameters:
- WIDTH, 8: operand and result width in bits; must be at least 2.
- SW, $clog2(WIDTH): width of `shift_width`; derived, not to be overridden.

Ports:
- CLK  in  1  clock, rising-edge.
- RST  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only while `busy`=0.
- a  in  WIDTH  operand; captured at start acceptance.
- shift_width  in  SW  shift amount; captured at start acceptance.
- mode  in  2  shift mode; captured at start acceptance. 00 LSL, 01 LSR, 10 ASR, 11 ROL.
- busy  out  1  operation in progress; registered.
- done  out  1  one-cycle pulse: `shifted_a` has just been updated.
- shifted_a  out  WIDTH  result; holds its value until the next `done`.

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE
  - `busy`=0, `done`=0, `shifted_a`=0
  - internal work register and counter cleared
- States: IDLE, SHIFT.
- IDLE:
  - `done` is cleared every cycle unless it is being set.
  - If `start`=1 at a rising edge k:
    - work<=`a`, cnt<=`shift_width`, md<=`mode`
    - state<=SHIFT, `busy`<=1
  - Otherwise nothing changes and `shifted_a` holds.
- SHIFT, at each rising edge:
  - If cnt!=0: work<=step(work, md), cnt<=cnt-1.
  - If cnt==0: `shifted_a`<=work, `done`<=1, `busy`<=0, state<=IDLE.
- step() shifts by exactly one bit:
  - LSL: {work[WIDTH-2:0],0}
  - LSR: {0,work[WIDTH-1:1]}
  - ASR: {work[WIDTH-1],work[WIDTH-1:1]}
  - ROL: {work[WIDTH-2:0],work[WIDTH-1]}
- Latency: `done` is high in the cycle following edge k+`shift_width`+1; there is no early exit. `shift_width`=0 gives `shifted_a`=`a` one cycle after acceptance.
- Out-of-range amounts (`shift_width`>=WIDTH, possible when WIDTH is not a power of 2) need no special-casing:
  - LSL and LSR produce 0.
  - ASR produces all sign bits.
  - ROL rotates by `shift_width` mod WIDTH.
- Handshake:
  - `start` while `busy`=1 is ignored; no queuing.
  - `start` in the same cycle as `done`=1 is accepted, because state is already IDLE.
  - Minimum issue interval is `shift_width`+2 cycles.
- Inputs `a`, `shift_width` and `mode` may change freely after acceptance without affecting the running operation.
- Reset during SHIFT: the operation is aborted, no `done` is produced, and `shifted_a` returns to 0.
- `done` and `busy` are never high together.

Decomposition:
- Package serial_shift_pkg:
  - mode constants MODE_LSL=2'b00, MODE_LSR=2'b01, MODE_ASR=2'b10, MODE_ROL=2'b11
  - state encoding ST_IDLE, ST_SHIFT
- Sub-module shift_step: combinational, parameter WIDTH, inputs (work, mode), output next. It is instantiated once, and its one-bit mode cases are checked exhaustively on their own.
- FSM, counter and output register stay in the top level.

Test Plan:
1. WIDTH=8, a=8'hB5, shift_width=3, mode=LSL, start pulse -> `busy` high for 4 cycles; `done` pulse with `shifted_a`=8'hA8.
2. Same operand and amount under the other modes -> LSR 8'h16, ASR 8'hF6, ROL 8'hAD. Each result holds after `done` until the next operation completes.
3. shift_width=0, a=8'h3C, any mode -> `done` one cycle after acceptance, `shifted_a`=8'h3C. Then shift_width=7, LSL, a=8'hFF -> 8'h80 after 8 cycles.
4. Handshake:
   - `start` with a=8'h01 issued while `busy` (current op a=8'h0F, sw=2, LSL) -> ignored; result 8'h3C only.
   - `start` in the `done` cycle with a=8'h01, sw=1, LSL -> accepted, next result 8'h02.
   - Change `a` mid-operation -> result unaffected.
5. RST driven low 2 cycles into an sw=5 operation -> `busy`, `done` and `shifted_a` go to 0 immediately, with no `done` afterwards. A following operation (a=8'h81, sw=1, ROL) returns 8'h03.
6. WIDTH=12 instance (SW=4):
   - a=12'h801, sw=13, LSL -> 12'h000
   - ROL -> 12'h003
   - ASR -> 12'hFFF
   - `done` 14 cycles after acceptance in each case.

Source files
------------

// File: rtl/serial_shift_pkg.sv
// Shared definitions for the serial variable shifter: mode codes and FSM states.
package serial_shift_pkg;

  // Shift mode, captured with the operand when an operation is accepted.
  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,  // logical shift left, zero fill
    MODE_LSR = 2'b01,  // logical shift right, zero fill
    MODE_ASR = 2'b10,  // arithmetic shift right, sign fill
    MODE_ROL = 2'b11   // rotate left
  } mode_e;

  // Controller states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage : serial_shift_pkg

// File: rtl/shift_step.sv
// One-bit shift step: moves the work word by exactly one position in the
// direction selected by mode, with the fill bit chosen per mode.
module shift_step
  import serial_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] work,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] next
);

  logic go_left;   // LSL and ROL move bits toward the MSB
  logic lsb_fill;  // bit entering at position 0 on a left move
  logic msb_fill;  // bit entering at position WIDTH-1 on a right move

  // Decode direction and fill bits from the mode.
  always_comb begin
    go_left  = (mode == MODE_LSL) || (mode == MODE_ROL);
    lsb_fill = (mode == MODE_ROL) ? work[WIDTH-1] : 1'b0;
    msb_fill = (mode == MODE_ASR) ? work[WIDTH-1] : 1'b0;
  end

  // Each result bit takes its lower or upper neighbour; the two end bits
  // take the fill bit on the side where nothing shifts in.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign next[gi] = go_left ? lsb_fill : work[gi+1];
      end else if (gi == WIDTH - 1) begin : g_msb
        assign next[gi] = go_left ? work[gi-1] : msb_fill;
      end else begin : g_mid
        assign next[gi] = go_left ? work[gi-1] : work[gi+1];
      end
    end
  endgenerate

endmodule : shift_step

// File: rtl/serial_variable_shifter.sv
// Time-multiplexed variable shifter. Operands are captured on start, then
// the work word is shifted one bit per clock until the captured amount is
// exhausted; the result is published with a one-cycle done pulse.
module serial_variable_shifter
  import serial_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [SW-1:0]    shift_width,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shifted_a
);

  localparam logic [SW-1:0] CNT_ONE = SW'(1);

  state_e           state_reg,     state_next;
  logic [WIDTH-1:0] work_reg,      work_next;
  logic [SW-1:0]    cnt_reg,       cnt_next;
  mode_e            md_reg,        md_next;
  logic             busy_reg,      busy_next;
  logic             done_reg,      done_next;
  logic [WIDTH-1:0] shifted_a_reg, shifted_a_next;

  logic [WIDTH-1:0] step_out;

  // Single shared one-bit shift network driven by the captured mode.
  shift_step #(
    .WIDTH (WIDTH)
  ) u_shift_step (
    .work (work_reg),
    .mode (md_reg),
    .next (step_out)
  );

  // Next-state logic: accept in IDLE, step or publish in SHIFT.
  always_comb begin
    state_next     = state_reg;
    work_next      = work_reg;
    cnt_next       = cnt_reg;
    md_next        = md_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;           // done is a single-cycle pulse
    shifted_a_next = shifted_a_reg;  // result holds until the next completion

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          work_next  = a;
          cnt_next   = shift_width;
          md_next    = mode_e'(mode);
          busy_next  = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_reg != '0) begin
          work_next = step_out;
          cnt_next  = cnt_reg - CNT_ONE;
        end else begin
          // No early exit: even amounts >= WIDTH run to completion, which
          // naturally yields zero / sign fill / modulo rotation.
          shifted_a_next = work_reg;
          done_next      = 1'b1;
          busy_next      = 1'b0;
          state_next     = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any running operation.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg     <= ST_IDLE;
      work_reg      <= '0;
      cnt_reg       <= '0;
      md_reg        <= MODE_LSL;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      shifted_a_reg <= '0;
    end else begin
      state_reg     <= state_next;
      work_reg      <= work_next;
      cnt_reg       <= cnt_next;
      md_reg        <= md_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      shifted_a_reg <= shifted_a_next;
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign shifted_a = shifted_a_reg;

endmodule : serial_variable_shifter
